// File: rtl/router_pkg.sv
// router_pkg: shared router widths, header field positions and header decode helper
package router_pkg;
  localparam int ROUTER_DATA_W = 8;
  localparam int ROUTER_FIFO_DEPTH = 16;
  localparam int LEN_MSB = 7;
  localparam int LEN_LSB = 2;
  localparam int ADDR_MSB = 1;
  localparam int ADDR_LSB = 0;
  function automatic logic [LEN_MSB-LEN_LSB:0] payload_len(input logic [ROUTER_DATA_W-1:0] hdr);
    return hdr[LEN_MSB:LEN_LSB];
  endfunction
endpackage

// File: rtl/router_fifo.sv
// router_fifo: per-destination output buffer that tracks packet length from stored header markers
module router_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = ROUTER_FIFO_DEPTH,
  parameter int WIDTH = ROUTER_DATA_W,
  parameter int LEN_W = LEN_MSB - LEN_LSB + 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] data_out
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [LEN_W:0] CNT_ONE = {{LEN_W{1'b0}}, 1'b1};
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LEN_W:0] pkt_cnt_q, pkt_cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH:0] mem_q [DEPTH];
  logic [WIDTH:0] mem_d [DEPTH];
  logic [WIDTH:0] rd_word;
  logic wr_en, rd_en;
  assign empty = wr_ptr_q == rd_ptr_q;
  assign full = wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0] && wr_ptr_q[AW] != rd_ptr_q[AW];
  assign wr_en = write_enb && !full;
  assign rd_en = read_enb && !empty;
  assign rd_word = mem_q[rd_ptr_q[AW-1:0]];
  assign data_out = data_out_q;
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q[AW-1:0]] = {lfd_state, data_in};
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end
  // header load counts payload plus the trailing parity byte
  always_comb begin
    pkt_cnt_d = rd_en && rd_word[WIDTH] ? (LEN_W+1)'(payload_len(rd_word[ROUTER_DATA_W-1:0])) + CNT_ONE :
                rd_en && pkt_cnt_q != '0 ? pkt_cnt_q - CNT_ONE : pkt_cnt_q;
    data_out_d = rd_en ? rd_word[WIDTH-1:0] : pkt_cnt_q == '0 ? '0 : data_out_q;
  end
  always_ff @(posedge clock) begin
    if (!resetn || soft_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pkt_cnt_q <= '0;
      data_out_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
      data_out_q <= data_out_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo: directed and random checks of router_fifo against a queue-based model
module tb_router_fifo;
  logic clock = 0, resetn = 0, soft_reset = 0, write_enb = 0, read_enb = 0, lfd_state = 0;
  logic [7:0] data_in = 0;
  logic full, empty;
  logic [7:0] data_out;
  int checks = 0, errors = 0;
  bit armed = 0;
  bit [8:0] q[$];
  bit [8:0] e;
  int m_cnt = 0;
  bit [7:0] m_dout = 0;
  bit m_rd, m_wr;
  router_fifo dut (
    .clock(clock), .resetn(resetn), .soft_reset(soft_reset), .write_enb(write_enb),
    .read_enb(read_enb), .lfd_state(lfd_state), .data_in(data_in),
    .full(full), .empty(empty), .data_out(data_out)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic wr(input bit lfd, input bit [7:0] d);
    write_enb = 1; lfd_state = lfd; data_in = d;
    tick();
    write_enb = 0; lfd_state = 0;
  endtask
  always @(posedge clock) begin
    if (!resetn || soft_reset) begin
      if (!resetn) armed = 1;
      q.delete(); m_cnt = 0; m_dout = 0;
    end else begin
      m_rd = read_enb && q.size() != 0;
      m_wr = write_enb && q.size() != 16;
      if (m_rd) begin
        e = q.pop_front();
        m_dout = e[7:0];
        if (e[8]) m_cnt = int'(e[7:2]) + 1;
        else if (m_cnt > 0) m_cnt--;
      end else if (m_cnt == 0) m_dout = 0;
      if (m_wr) q.push_back({lfd_state, data_in});
    end
  end
  always @(negedge clock) if (armed) begin
    chk("model_empty", empty, q.size() == 0);
    chk("model_full", full, q.size() == 16);
    chk("model_data_out", data_out, m_dout);
  end
  initial begin
    bit [7:0] pkt [5] = '{8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'hD1};
    bit [7:0] rnd [10];
    tick(); tick();
    resetn = 1;
    for (int i = 0; i < 5; i++) wr(1'($urandom), 8'($urandom));
    resetn = 0; tick();
    chk("reset_empty", empty, 1); chk("reset_full", full, 0); chk("reset_dout", data_out, 0);
    resetn = 1; read_enb = 1; tick(); read_enb = 0;
    chk("read_after_reset", data_out, 0);
    wr(1, pkt[0]);
    for (int i = 1; i < 5; i++) wr(0, pkt[i]);
    read_enb = 1;
    for (int i = 0; i < 5; i++) begin tick(); chk($sformatf("pkt_byte%0d", i), data_out, pkt[i]); end
    read_enb = 0; tick();
    chk("pkt_idle_zero", data_out, 0); chk("pkt_empty", empty, 1);
    for (int i = 0; i < 16; i++) wr(0, 8'(i));
    chk("full_after_16", full, 1);
    wr(0, 8'hFF);
    chk("full_after_drop", full, 1);
    read_enb = 1; write_enb = 1; data_in = 8'h55; tick(); write_enb = 0;
    chk("simul_full_dout", data_out, 0); chk("simul_full_clear", full, 0);
    for (int i = 1; i < 16; i++) begin tick(); chk($sformatf("drain%0d", i), data_out, i); end
    read_enb = 0; tick();
    chk("drain_empty", empty, 1);
    wr(1, 8'h11);
    for (int i = 0; i < 5; i++) wr(0, 8'(8'h21 + i));
    read_enb = 1; tick(); chk("sr_hdr", data_out, 8'h11);
    tick(); chk("sr_pay", data_out, 8'h21);
    read_enb = 0; soft_reset = 1; write_enb = 1; data_in = 8'h99; tick();
    soft_reset = 0; write_enb = 0;
    chk("sr_empty", empty, 1); chk("sr_dout", data_out, 0);
    tick(); chk("sr_write_dropped", empty, 1); chk("sr_cnt_clear", data_out, 0);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) begin rnd[i] = 8'($urandom); wr(0, rnd[i]); end
      chk("wrap_not_full", full, 0);
      read_enb = 1;
      for (int i = 0; i < 10; i++) begin tick(); chk($sformatf("wrap%0d_%0d", r, i), data_out, rnd[i]); end
      read_enb = 0; tick();
      chk("wrap_empty", empty, 1);
    end
    for (int i = 0; i < 600; i++) begin
      write_enb = 1'($urandom_range(0, 2) != 0);
      read_enb = 1'($urandom_range(0, 2) != 0);
      lfd_state = $urandom_range(0, 3) == 0;
      data_in = 8'($urandom);
      soft_reset = $urandom_range(0, 63) == 0;
      resetn = $urandom_range(0, 127) != 0;
      tick();
    end
    write_enb = 0; read_enb = 0; soft_reset = 0; resetn = 1;
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
